// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers hex nibbles from a multiplexed 7-segment bus
// Optional macro SEG7_ACTIVE_LOW_EN: treat seg and an as active-low inputs.
module seg7_scan_decoder #(
   parameter int DIGITS = 4,
   parameter int SETTLE = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     valid,
   output logic [DIGITS-1:0]     err,
   output logic                  frame_done
);

   localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   logic [6:0]          seg_in;
   logic [DIGITS-1:0]   an_in;
   logic [6:0]          sample_seg_q, sample_seg_d, last_seg_q, last_seg_d;
   logic [DIGITS-1:0]   sample_an_q, sample_an_d, last_an_q, last_an_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                committed_q, committed_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [DIGITS-1:0]   valid_q, valid_d, err_q, err_d, seen_q, seen_d;
   logic                frame_done_q, frame_done_d;
   logic                same, one_hot, commit, hit;
   logic [3:0]          nib;
   logic [DIGITS-1:0]   commit_mask;

   // Polarity normalisation at the input register
   always_comb begin
`ifdef SEG7_ACTIVE_LOW_EN
      seg_in = ~seg;
      an_in  = ~an;
`else
      seg_in = seg;
      an_in  = an;
`endif
   end

   // Glyph lookup: returns {hit, nibble}
   function automatic logic [4:0] glyph(input logic [6:0] s);
      case (s)
         7'h7E: glyph = {1'b1, 4'h0};
         7'h30: glyph = {1'b1, 4'h1};
         7'h6D: glyph = {1'b1, 4'h2};
         7'h79: glyph = {1'b1, 4'h3};
         7'h33: glyph = {1'b1, 4'h4};
         7'h5B: glyph = {1'b1, 4'h5};
         7'h5F: glyph = {1'b1, 4'h6};
         7'h70: glyph = {1'b1, 4'h7};
         7'h7F: glyph = {1'b1, 4'h8};
         7'h7B: glyph = {1'b1, 4'h9};
         7'h77: glyph = {1'b1, 4'hA};
         7'h1F: glyph = {1'b1, 4'hB};
         7'h4E: glyph = {1'b1, 4'hC};
         7'h3D: glyph = {1'b1, 4'hD};
         7'h4F: glyph = {1'b1, 4'hE};
         7'h47: glyph = {1'b1, 4'hF};
         default: glyph = 5'b0_0000;
      endcase
   endfunction

   // Settle counting, commit decision, register-file update and frame tracking
   always_comb begin
      sample_seg_d = seg_in;
      sample_an_d  = an_in;
      last_seg_d   = sample_seg_q;
      last_an_d    = sample_an_q;
      same    = (sample_seg_q == last_seg_q) && (sample_an_q == last_an_q);
      one_hot = (sample_an_q != '0) && ((sample_an_q & (sample_an_q - 1'b1)) == '0);
      cnt_d       = 4'd0;
      committed_d = 1'b0;
      commit      = 1'b0;
      if (same && one_hot) begin
         cnt_d       = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + 4'd1;
         commit      = (cnt_d == SETTLE_M1) && !committed_q;
         committed_d = committed_q | commit;
      end
      {hit, nib}  = glyph(sample_seg_q);
      commit_mask = commit ? sample_an_q : '0;
      digits_d = digits_q;
      valid_d  = valid_q;
      err_d    = err_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (commit_mask[i]) begin
            if (hit) digits_d[4*i +: 4] = nib;
            valid_d[i] = hit;
            err_d[i]   = !hit;
         end
      end
      // A completed frame clears seen while a same-cycle commit opens the next one
      frame_done_d = &seen_q;
      seen_d       = ((&seen_q) ? '0 : seen_q) | commit_mask;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         sample_seg_q <= '0;
         sample_an_q  <= '0;
         last_seg_q   <= '0;
         last_an_q    <= '0;
         cnt_q        <= '0;
         committed_q  <= 1'b0;
         digits_q     <= '0;
         valid_q      <= '0;
         err_q        <= '0;
         seen_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         sample_seg_q <= sample_seg_d;
         sample_an_q  <= sample_an_d;
         last_seg_q   <= last_seg_d;
         last_an_q    <= last_an_d;
         cnt_q        <= cnt_d;
         committed_q  <= committed_d;
         digits_q     <= digits_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         seen_q       <= seen_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digits     = digits_q;
   assign valid      = valid_q;
   assign err        = err_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
`define CHECK(tag, obs, exp) \
    begin \
        total++; \
        assert ((obs) === (exp)) else begin \
            bad++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_seg7_scan_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        frame_done;
    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;

    seg7_scan_decoder #(.DIGITS(4), .SETTLE(3)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .digits(digits), .valid(valid), .err(err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
`ifdef SEG7_ACTIVE_LOW_EN
        an  = ~a;
        seg = ~s;
`else
        an  = a;
        seg = s;
`endif
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        drive(4'b0000, 7'h00);
        step(2);
        total++;
        if (digits !== 16'h0000) begin
            bad++;
            $error("FAIL rst_digits observed=%0h expected=0", digits);
        end
        total++;
        if (valid !== 4'h0) begin
            bad++;
            $error("FAIL rst_valid observed=%0h expected=0", valid);
        end
        total++;
        if (err !== 4'h0) begin
            bad++;
            $error("FAIL rst_err observed=%0h expected=0", err);
        end
        total++;
        if (frame_done !== 1'b0) begin
            bad++;
            $error("FAIL rst_fd observed=%0h expected=0", frame_done);
        end
        reset = 1'b1;

        drive(4'b0001, 7'h30);
        step(3);
        `CHECK("lat_not_yet", valid, 4'h0)
        step(1);
        `CHECK("d0_digits", digits, 16'h0001)
        `CHECK("d0_valid", valid, 4'b0001)
        `CHECK("d0_err", err, 4'b0000)
        step(10);
        `CHECK("d0_hold_digits", digits, 16'h0001)
        `CHECK("d0_hold_fd", fd_cnt, 0)

        drive(4'b0001, 7'h7E); step(5);
        drive(4'b0010, 7'h6D); step(5);
        drive(4'b0100, 7'h77); step(5);
        `CHECK("scan_no_early_fd", fd_cnt, 0)
        drive(4'b1000, 7'h47); step(5);
        `CHECK("scan_fd_high", frame_done, 1'b1)
        step(1);
        `CHECK("scan_fd_low", frame_done, 1'b0)
        `CHECK("scan_digits", digits, 16'hFA20)
        `CHECK("scan_valid", valid, 4'hF)
        `CHECK("scan_fd_count", fd_cnt, 1)

        drive(4'b0010, 7'h30); step(2);
        drive(4'b0000, 7'h00); step(6);
        `CHECK("short_digits", digits, 16'hFA20)
        `CHECK("short_valid", valid, 4'hF)

        drive(4'b0100, 7'h5B); step(5);
        `CHECK("d2_five", digits, 16'hF520)
        drive(4'b0100, 7'h00); step(4);
        `CHECK("blank_err", err, 4'b0100)
        `CHECK("blank_valid", valid, 4'b1011)
        `CHECK("blank_digits", digits, 16'hF520)
        drive(4'b0100, 7'h5B); step(5);
        `CHECK("reclr_err", err, 4'b0000)
        `CHECK("reclr_valid", valid, 4'hF)

        drive(4'b0011, 7'h7F); step(8);
        `CHECK("multihot_digits", digits, 16'hF520)
        `CHECK("multihot_valid", valid, 4'hF)
        drive(4'b0000, 7'h7F); step(8);
        `CHECK("zero_an_digits", digits, 16'hF520)
        `CHECK("zero_an_err", err, 4'h0)
        `CHECK("no_extra_fd", fd_cnt, 1)

        drive(4'b0001, 7'h7F); step(2);
        reset = 1'b0; step(1);
        `CHECK("mid_rst_digits", digits, 16'h0000)
        `CHECK("mid_rst_valid", valid, 4'h0)
        `CHECK("mid_rst_err", err, 4'h0)
        reset = 1'b1;
        step(3);
        total++;
        if (valid !== 4'h0) begin
            bad++;
            $error("FAIL post_rst_wait observed=%0h expected=0", valid);
        end
        step(1);
        `CHECK("post_rst_digits", digits, 16'h0008)
        `CHECK("post_rst_valid", valid, 4'b0001)

        drive(4'b0001, 7'h7E); step(4);
        `CHECK("zero_glyph_digits", digits, 16'h0000)
        `CHECK("zero_glyph_valid", valid, 4'b0001)

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 7-segment display interface: watches a time-multiplexed segment bus and the matching digit enable lines.
- Recovers the hex nibble shown on each digit position and holds it in a register file with per-digit valid and error flags.
- Used by the bench and the board self-check path to read back what the segment decoders drive, without probing the internal nibbles.

Parameters:
DIGITS, 4, number of multiplexed digit positions (1..8)
SETTLE, 3, consecutive identical samples required before a digit is committed (2..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
seg  input  7  segment levels, seg[6]=a ... seg[0]=g, 1 = lit
an  input  DIGITS  digit enables, one-hot, an[i]=1 selects digit i
digits  output  4*DIGITS  recovered nibbles, digit i at [4i+3:4i]
valid  output  DIGITS  digit i holds a successfully decoded nibble
err  output  DIGITS  last committed pattern on digit i was not a hex glyph
frame_done  output  1  one-cycle pulse: every digit committed since last pulse

Behaviour:
- Reset is synchronous and active-low. On a clk edge with reset=0: digits=0, valid=0, err=0, frame_done=0, settle counter=0, seen-mask=0, last-sample registers=0, committed flag=0.
- Every cycle, {an,seg} is registered as the sample. Decode logic acts on the registered sample.
- Settle counter:
  - Increments (saturating at SETTLE) while the sample equals the previous sample and an is exactly one-hot.
  - Resets to 0 when the sample changes, or when an is all-zero or multi-hot.
- Commit:
  - Occurs on the cycle the counter reaches SETTLE-1 with the committed flag clear; the committed flag is then set.
  - The flag clears on any sample change, so a stable digit commits exactly once per dwell.
  - Latency: commit takes effect SETTLE+1 clk edges after the pattern is first presented.
- Glyph table (seg hex, bit6=a): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
- On commit for digit i:
  - Pattern in table: digits[i]=nibble, valid[i]=1, err[i]=0.
  - Pattern not in table (including blank 00): digits[i] unchanged, valid[i]=0, err[i]=1.
  - In both cases, set seen[i].
- frame_done:
  - When seen becomes all ones, frame_done=1 for exactly one cycle, on the edge after the completing commit.
  - seen clears on that same edge. A commit arriving that same cycle sets seen for the next frame.
- an all-zero or multi-hot: no commit and no flag change. Existing digits, valid and err hold.
- Re-commit of the same digit before the frame completes: the value is updated and the seen bit stays set.
- Reset asserted mid-dwell: all state cleared. After reset releases, a full SETTLE dwell is required before the next commit.
- Outputs are registered and change only on clk edges.

Optional Feature:
- Macro: SEG7_ACTIVE_LOW_EN.
- When defined: seg and an are interpreted active-low (common-anode boards). Both are inverted at the input register, and all rules above apply to the inverted values.
- When undefined: inputs are active-high as specified.
- Outputs are unaffected in both cases.

Test Plan:
- Reset, then an=0001 seg=30 held 3 cycles -> digits[3:0]=1, valid=0001, err=0000 on the edge after the 3rd sample; no second commit while held 10 more cycles.
- Scan an=0001/0010/0100/1000 with seg=7E/6D/77/47, each held 5 cycles -> digits=F A 2 0 (0xFA20), valid=1111, frame_done pulses exactly once after the 4th commit.
- an=0010 seg=30 held only 2 cycles, then changed -> no commit, digit 1 and valid[1] unchanged.
- an=0100 seg=00 held 4 cycles after digit 2 held 5 -> err[2]=1, valid[2]=0, digits[11:8] stays 5; a later seg=5B dwell clears err[2].
- an=0011 or an=0000 with seg=7F held 8 cycles -> no flag or digit changes; reset low mid-dwell -> all outputs 0.
- With SEG7_ACTIVE_LOW_EN: an=1110 seg=~7E (0x01) held 3 cycles -> digits[3:0]=0, valid[0]=1.
